exe_ctrl_issue: RTL and testbench



---
 rtl/exe_ctrl_issue.sv | 238 +++++++++++++++++++++++
 tb/tb_exe_ctrl_issue.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_ctrl_issue.sv
// ID-to-EXE issue stage: decodes the ID fields into ALU commands and control
// enables, registers them into EXE, holds the NZCV status register, and checks
// the condition field against flags that include a same-cycle ALU update.
module exe_ctrl_issue (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [3:0] cond,
    input  logic [1:0] mode,
    input  logic [3:0] opcode,
    input  logic       s,
    input  logic       freeze,
    input  logic       flush,
    input  logic       alu_n,
    input  logic       alu_z,
    input  logic       alu_c,
    input  logic       alu_v,
    output logic [3:0] EXE_CMD,
    output logic       exe_valid,
    output logic       exe_s,
    output logic       wb_en,
    output logic       mem_r_en,
    output logic       mem_w_en,
    output logic       branch,
    output logic       c,
    output logic [3:0] status,
    output logic       cond_fail
);

    localparam int unsigned CMD_W  = 4;
    localparam int unsigned FLAG_W = 4;

    // ALU command encodings
    localparam logic [CMD_W-1:0] CMD_BR  = CMD_W'(0);
    localparam logic [CMD_W-1:0] CMD_MOV = CMD_W'(1);
    localparam logic [CMD_W-1:0] CMD_ADD = CMD_W'(2);
    localparam logic [CMD_W-1:0] CMD_ADC = CMD_W'(3);
    localparam logic [CMD_W-1:0] CMD_SUB = CMD_W'(4);
    localparam logic [CMD_W-1:0] CMD_SBC = CMD_W'(5);
    localparam logic [CMD_W-1:0] CMD_AND = CMD_W'(6);
    localparam logic [CMD_W-1:0] CMD_ORR = CMD_W'(7);
    localparam logic [CMD_W-1:0] CMD_EOR = CMD_W'(8);
    localparam logic [CMD_W-1:0] CMD_MVN = CMD_W'(9);

    // Instruction modes
    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    // Status register bit positions within {N,Z,C,V}
    localparam int unsigned BIT_N = 3;
    localparam int unsigned BIT_Z = 2;
    localparam int unsigned BIT_C = 1;
    localparam int unsigned BIT_V = 0;

    logic             dec_legal;
    logic [CMD_W-1:0] dec_cmd;
    logic             dec_wb;
    logic             dec_mr;
    logic             dec_mw;
    logic             dec_br;
    logic             dec_s;

    logic [FLAG_W-1:0] alu_flags;
    logic [FLAG_W-1:0] eff_flags;
    logic              flag_n;
    logic              flag_z;
    logic              flag_c;
    logic              flag_v;
    logic              cond_pass;
    logic              issue;
    logic              exe_load;
    logic              status_load;

    logic [CMD_W-1:0] nxt_cmd;
    logic             nxt_valid;
    logic             nxt_s;
    logic             nxt_wb;
    logic             nxt_mr;
    logic             nxt_mw;
    logic             nxt_br;

    assign alu_flags = {alu_n, alu_z, alu_c, alu_v};

    // Instruction field decode into command, enables and effective S bit
    always_comb begin
        dec_legal = 1'b0;
        dec_cmd   = CMD_BR;
        dec_wb    = 1'b0;
        dec_mr    = 1'b0;
        dec_mw    = 1'b0;
        dec_br    = 1'b0;
        dec_s     = 1'b0;
        case (mode)
            MODE_DP: begin
                dec_legal = 1'b1;
                dec_wb    = 1'b1;
                dec_s     = s;
                case (opcode)
                    4'b1101: dec_cmd = CMD_MOV;
                    4'b1111: dec_cmd = CMD_MVN;
                    4'b0100: dec_cmd = CMD_ADD;
                    4'b0101: dec_cmd = CMD_ADC;
                    4'b0010: dec_cmd = CMD_SUB;
                    4'b0110: dec_cmd = CMD_SBC;
                    4'b0000: dec_cmd = CMD_AND;
                    4'b1100: dec_cmd = CMD_ORR;
                    4'b0001: dec_cmd = CMD_EOR;
                    4'b1010: begin
                        // CMP: compare only, always sets flags
                        dec_cmd = CMD_SUB;
                        dec_wb  = 1'b0;
                        dec_s   = 1'b1;
                    end
                    4'b1000: begin
                        // TST: test only, always sets flags
                        dec_cmd = CMD_AND;
                        dec_wb  = 1'b0;
                        dec_s   = 1'b1;
                    end
                    default: begin
                        dec_legal = 1'b0;
                        dec_wb    = 1'b0;
                        dec_s     = 1'b0;
                    end
                endcase
            end
            MODE_MEM: begin
                if (opcode == 4'b0100) begin
                    // s selects LDR (1) or STR (0); address uses ADD
                    dec_legal = 1'b1;
                    dec_cmd   = CMD_ADD;
                    dec_mr    = s;
                    dec_mw    = ~s;
                    dec_wb    = s;
                end
            end
            MODE_BR: begin
                dec_legal = 1'b1;
                dec_br    = 1'b1;
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    // Flags seen by the ID instruction: bypass a flag-setting op now in EXE
    assign eff_flags = (exe_valid && exe_s) ? alu_flags : status;
    assign flag_n    = eff_flags[BIT_N];
    assign flag_z    = eff_flags[BIT_Z];
    assign flag_c    = eff_flags[BIT_C];
    assign flag_v    = eff_flags[BIT_V];

    // Condition field evaluation against the effective flags
    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = ~flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = ~flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = ~flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = ~flag_v;
            4'b1000: cond_pass = flag_c & ~flag_z;
            4'b1001: cond_pass = ~flag_c | flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_pass = flag_z | (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    assign cond_fail = ~cond_pass;
    assign issue     = id_valid & dec_legal & cond_pass;

    // EXE register advances unless frozen; flush wins and injects a bubble
    assign exe_load    = flush | ~freeze;
    assign status_load = exe_valid & exe_s & (~freeze | flush);

    // Next EXE contents: decoded instruction or an all-zero bubble
    always_comb begin
        nxt_valid = 1'b0;
        nxt_cmd   = CMD_BR;
        nxt_s     = 1'b0;
        nxt_wb    = 1'b0;
        nxt_mr    = 1'b0;
        nxt_mw    = 1'b0;
        nxt_br    = 1'b0;
        if (issue && !flush) begin
            nxt_valid = 1'b1;
            nxt_cmd   = dec_cmd;
            nxt_s     = dec_s;
            nxt_wb    = dec_wb;
            nxt_mr    = dec_mr;
            nxt_mw    = dec_mw;
            nxt_br    = dec_br;
        end
    end

    // ID/EXE pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            exe_valid <= 1'b0;
            EXE_CMD   <= CMD_BR;
            exe_s     <= 1'b0;
            wb_en     <= 1'b0;
            mem_r_en  <= 1'b0;
            mem_w_en  <= 1'b0;
            branch    <= 1'b0;
        end else if (exe_load) begin
            exe_valid <= nxt_valid;
            EXE_CMD   <= nxt_cmd;
            exe_s     <= nxt_s;
            wb_en     <= nxt_wb;
            mem_r_en  <= nxt_mr;
            mem_w_en  <= nxt_mw;
            branch    <= nxt_br;
        end
    end

    // NZCV status register; a held EXE instruction commits only when it leaves
    always_ff @(posedge clk) begin
        if (rst) begin
            status <= '0;
        end else if (status_load) begin
            status <= alu_flags;
        end
    end

    // Carry-in comes straight from the committed status, never bypassed
    assign c = status[BIT_C];

endmodule

// File: tb/tb_exe_ctrl_issue.sv
// Bench for exe_ctrl_issue: decode table, hand-written pipeline corner cases,
// and a randomized run checked against a behavioural model.
module tb_exe_ctrl_issue;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [3:0] cond;
    logic [1:0] mode;
    logic [3:0] opcode;
    logic       s;
    logic       freeze;
    logic       flush;
    logic       alu_n, alu_z, alu_c, alu_v;
    logic [3:0] EXE_CMD;
    logic       exe_valid, exe_s, wb_en, mem_r_en, mem_w_en, branch, c;
    logic [3:0] status;
    logic       cond_fail;

    int n_checks = 0;
    int n_errors = 0;

    exe_ctrl_issue dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .cond(cond), .mode(mode),
        .opcode(opcode), .s(s), .freeze(freeze), .flush(flush),
        .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .EXE_CMD(EXE_CMD), .exe_valid(exe_valid), .exe_s(exe_s), .wb_en(wb_en),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .branch(branch), .c(c),
        .status(status), .cond_fail(cond_fail)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       idv;
        logic [3:0] cnd;
        logic [1:0] md;
        logic [3:0] op;
        logic       sb;
        logic [3:0] e_cmd;
        logic       e_valid, e_es, e_wb, e_mr, e_mw, e_br, e_cf;
    } vec_t;

    vec_t vecs[25];

    // Data-processing opcode table: command, or -1 for illegal
    int dp_cmd[16];
    bit dp_cmp_only[16];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_exe(input string tag, input logic [3:0] e_cmd, input logic e_valid,
                             input logic e_es, input logic e_wb, input logic e_mr,
                             input logic e_mw, input logic e_br);
        chk({tag, ".EXE_CMD"}, EXE_CMD, e_cmd);
        chk({tag, ".exe_valid"}, 4'(exe_valid), 4'(e_valid));
        chk({tag, ".exe_s"}, 4'(exe_s), 4'(e_es));
        chk({tag, ".wb_en"}, 4'(wb_en), 4'(e_wb));
        chk({tag, ".mem_r_en"}, 4'(mem_r_en), 4'(e_mr));
        chk({tag, ".mem_w_en"}, 4'(mem_w_en), 4'(e_mw));
        chk({tag, ".branch"}, 4'(branch), 4'(e_br));
    endtask

    task automatic check_status(input string tag, input logic [3:0] e_st);
        chk({tag, ".status"}, status, e_st);
        chk({tag, ".c"}, 4'(c), 4'(e_st[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic idv, input logic [3:0] cn, input logic [1:0] md,
                         input logic [3:0] op, input logic sb);
        id_valid = idv; cond = cn; mode = md; opcode = op; s = sb;
    endtask

    task automatic set_alu(input logic [3:0] f);
        {alu_n, alu_z, alu_c, alu_v} = f;
    endtask

    function automatic vec_t mkv(input logic idv, input logic [3:0] cn, input logic [1:0] md,
                                 input logic [3:0] op, input logic sb, input logic [3:0] ec,
                                 input logic ev, input logic ees, input logic ewb,
                                 input logic emr, input logic emw, input logic ebr,
                                 input logic ecf);
        vec_t v;
        v.idv = idv; v.cnd = cn; v.md = md; v.op = op; v.sb = sb;
        v.e_cmd = ec; v.e_valid = ev; v.e_es = ees; v.e_wb = ewb;
        v.e_mr = emr; v.e_mw = emw; v.e_br = ebr; v.e_cf = ecf;
        return v;
    endfunction

    // ARM conditions: pairs share a predicate, the odd code negates it
    function automatic bit model_pass(input logic [3:0] cn, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (cn[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ cn[0];
    endfunction

    // Reference decode: {legal, cmd, s, wb, mr, mw, br}
    task automatic model_decode(input logic [1:0] md, input logic [3:0] op, input logic sb,
                                output bit legal, output logic [3:0] cmd, output bit es,
                                output bit wb, output bit mr, output bit mw, output bit br);
        legal = 0; cmd = 0; es = 0; wb = 0; mr = 0; mw = 0; br = 0;
        if (md == 2'b00 && dp_cmd[op] >= 0) begin
            legal = 1;
            cmd = 4'(dp_cmd[op]);
            wb = !dp_cmp_only[op];
            es = dp_cmp_only[op] ? 1'b1 : sb;
        end else if (md == 2'b01 && op == 4'd4) begin
            legal = 1; cmd = 4'd2; wb = sb; mr = sb; mw = !sb;
        end else if (md == 2'b10) begin
            legal = 1; br = 1;
        end
    endtask

    // Model state
    logic [3:0] m_cmd, m_status;
    bit m_valid, m_es, m_wb, m_mr, m_mw, m_br;

    initial begin
        bit lg, es, wb, mr, mw, br, pass, upd;
        logic [3:0] cmd, f, alu_now;
        logic [3:0] n_cmd, n_status;
        bit n_valid, n_es, n_wb, n_mr, n_mw, n_br;

        for (int i = 0; i < 16; i++) begin dp_cmd[i] = -1; dp_cmp_only[i] = 0; end
        dp_cmd[4'hD] = 1; dp_cmd[4'hF] = 9; dp_cmd[4'h4] = 2; dp_cmd[4'h5] = 3;
        dp_cmd[4'h2] = 4; dp_cmd[4'h6] = 5; dp_cmd[4'h0] = 6; dp_cmd[4'hC] = 7;
        dp_cmd[4'h1] = 8; dp_cmd[4'hA] = 4; dp_cmd[4'h8] = 6;
        dp_cmp_only[4'hA] = 1; dp_cmp_only[4'h8] = 1;

        // With status and ALU flags all zero, the effective flags are 0000
        vecs[0]  = mkv(1, 4'hE, 2'd0, 4'hD, 0, 4'd1, 1, 0, 1, 0, 0, 0, 0);
        vecs[1]  = mkv(1, 4'hE, 2'd0, 4'hF, 1, 4'd9, 1, 1, 1, 0, 0, 0, 0);
        vecs[2]  = mkv(1, 4'hE, 2'd0, 4'h4, 0, 4'd2, 1, 0, 1, 0, 0, 0, 0);
        vecs[3]  = mkv(1, 4'hE, 2'd0, 4'h5, 0, 4'd3, 1, 0, 1, 0, 0, 0, 0);
        vecs[4]  = mkv(1, 4'hE, 2'd0, 4'h2, 1, 4'd4, 1, 1, 1, 0, 0, 0, 0);
        vecs[5]  = mkv(1, 4'hE, 2'd0, 4'h6, 0, 4'd5, 1, 0, 1, 0, 0, 0, 0);
        vecs[6]  = mkv(1, 4'hE, 2'd0, 4'h0, 0, 4'd6, 1, 0, 1, 0, 0, 0, 0);
        vecs[7]  = mkv(1, 4'hE, 2'd0, 4'hC, 0, 4'd7, 1, 0, 1, 0, 0, 0, 0);
        vecs[8]  = mkv(1, 4'hE, 2'd0, 4'h1, 0, 4'd8, 1, 0, 1, 0, 0, 0, 0);
        vecs[9]  = mkv(1, 4'hE, 2'd0, 4'hA, 0, 4'd4, 1, 1, 0, 0, 0, 0, 0);
        vecs[10] = mkv(1, 4'hE, 2'd0, 4'h8, 0, 4'd6, 1, 1, 0, 0, 0, 0, 0);
        vecs[11] = mkv(1, 4'hE, 2'd1, 4'h4, 1, 4'd2, 1, 0, 1, 1, 0, 0, 0);
        vecs[12] = mkv(1, 4'hE, 2'd1, 4'h4, 0, 4'd2, 1, 0, 0, 0, 1, 0, 0);
        vecs[13] = mkv(1, 4'hE, 2'd2, 4'h7, 1, 4'd0, 1, 0, 0, 0, 0, 1, 0);
        vecs[14] = mkv(1, 4'hE, 2'd3, 4'h4, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0);
        vecs[15] = mkv(1, 4'hE, 2'd0, 4'h3, 1, 4'd0, 0, 0, 0, 0, 0, 0, 0);
        vecs[16] = mkv(1, 4'hE, 2'd1, 4'h5, 1, 4'd0, 0, 0, 0, 0, 0, 0, 0);
        vecs[17] = mkv(1, 4'hF, 2'd0, 4'h4, 0, 4'd0, 0, 0, 0, 0, 0, 0, 1);
        vecs[18] = mkv(1, 4'h0, 2'd0, 4'h4, 0, 4'd0, 0, 0, 0, 0, 0, 0, 1);
        vecs[19] = mkv(1, 4'h1, 2'd0, 4'h4, 0, 4'd2, 1, 0, 1, 0, 0, 0, 0);
        vecs[20] = mkv(1, 4'h9, 2'd0, 4'h4, 0, 4'd2, 1, 0, 1, 0, 0, 0, 0);
        vecs[21] = mkv(1, 4'hB, 2'd0, 4'h4, 0, 4'd0, 0, 0, 0, 0, 0, 0, 1);
        vecs[22] = mkv(1, 4'hC, 2'd0, 4'h4, 0, 4'd2, 1, 0, 1, 0, 0, 0, 0);
        vecs[23] = mkv(0, 4'hE, 2'd0, 4'h4, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0);
        vecs[24] = mkv(1, 4'h2, 2'd2, 4'h0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 1);

        rst = 1; freeze = 0; flush = 0; set_alu(4'h0);
        drive(1, 4'hE, 2'd0, 4'h4, 0);

        // Reset with a live ADD in ID
        tick();
        check_exe("reset", 4'd0, 0, 0, 0, 0, 0, 0);
        check_status("reset", 4'h0);
        rst = 0;
        tick();
        check_exe("add_after_reset", 4'd2, 1, 0, 1, 0, 0, 0);

        // Decode table
        foreach (vecs[i]) begin
            drive(vecs[i].idv, vecs[i].cnd, vecs[i].md, vecs[i].op, vecs[i].sb);
            #1;
            chk($sformatf("vec%0d.cond_fail", i), 4'(cond_fail), 4'(vecs[i].e_cf));
            tick();
            check_exe($sformatf("vec%0d", i), vecs[i].e_cmd, vecs[i].e_valid, vecs[i].e_es,
                      vecs[i].e_wb, vecs[i].e_mr, vecs[i].e_mw, vecs[i].e_br);
            check_status($sformatf("vec%0d", i), 4'h0);
        end

        // SUBS sets Z,C; BEQ behind it passes through the bypass
        drive(1, 4'hE, 2'd0, 4'h2, 1);
        tick();
        check_exe("subs", 4'd4, 1, 1, 1, 0, 0, 0);
        set_alu(4'b0110);
        drive(1, 4'h0, 2'd2, 4'h0, 0);
        #1;
        chk("beq_bypass.cond_fail", 4'(cond_fail), 4'd0);
        tick();
        check_exe("beq", 4'd0, 1, 0, 0, 0, 0, 1);
        check_status("subs_commit", 4'b0110);

        // CMP then ADDNE with Z=1 from the ALU: ADDNE becomes a bubble
        set_alu(4'h0);
        drive(1, 4'hE, 2'd0, 4'hA, 0);
        tick();
        check_exe("cmp", 4'd4, 1, 1, 0, 0, 0, 0);
        set_alu(4'b0100);
        drive(1, 4'h1, 2'd0, 4'h4, 0);
        #1;
        chk("addne.cond_fail", 4'(cond_fail), 4'd1);
        tick();
        check_exe("addne", 4'd0, 0, 0, 0, 0, 0, 0);
        check_status("cmp_commit", 4'b0100);

        // ADCS held by freeze for three cycles, then one commit
        drive(1, 4'hE, 2'd0, 4'h5, 1);
        tick();
        check_exe("adcs", 4'd3, 1, 1, 1, 0, 0, 0);
        set_alu(4'b1011);
        freeze = 1;
        drive(1, 4'hE, 2'd0, 4'hD, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_exe($sformatf("frz%0d", k), 4'd3, 1, 1, 1, 0, 0, 0);
            check_status($sformatf("frz%0d", k), 4'b0100);
        end
        drive(1, 4'h0, 2'd0, 4'hD, 0);
        #1;
        chk("frz_eq.cond_fail", 4'(cond_fail), 4'd1);
        drive(1, 4'h3, 2'd0, 4'hD, 0);
        #1;
        chk("frz_cc.cond_fail", 4'(cond_fail), 4'd1);
        freeze = 0;
        drive(0, 4'hE, 2'd0, 4'h4, 0);
        tick();
        check_exe("frz_release", 4'd0, 0, 0, 0, 0, 0, 0);
        check_status("frz_release", 4'b1011);
        set_alu(4'b0000);
        tick();
        check_status("frz_once", 4'b1011);

        // freeze+flush with SUBS in EXE: commit once, EXE becomes bubble
        drive(1, 4'hE, 2'd0, 4'h2, 1);
        tick();
        set_alu(4'b0001);
        freeze = 1; flush = 1;
        tick();
        check_exe("frz_flush", 4'd0, 0, 0, 0, 0, 0, 0);
        check_status("frz_flush", 4'b0001);
        freeze = 0; flush = 0;
        drive(0, 4'hE, 2'd0, 4'h4, 0);
        set_alu(4'b1110);
        tick();
        check_status("frz_flush_once", 4'b0001);

        // Reset mid-stream discards the in-flight flag update
        drive(1, 4'hE, 2'd0, 4'h2, 1);
        tick();
        set_alu(4'b1111);
        rst = 1;
        tick();
        check_exe("mid_reset", 4'd0, 0, 0, 0, 0, 0, 0);
        check_status("mid_reset", 4'h0);
        rst = 0;

        // Randomized run against the model; model starts from reset state
        m_cmd = 0; m_status = 0; m_valid = 0; m_es = 0; m_wb = 0; m_mr = 0; m_mw = 0; m_br = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst    = ($urandom_range(0, 59) == 0);
            freeze = ($urandom_range(0, 4) == 0);
            flush  = ($urandom_range(0, 7) == 0);
            id_valid = ($urandom_range(0, 7) != 0);
            cond   = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
            mode   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
            opcode = (mode == 2'd1 && $urandom_range(0, 3) != 0) ? 4'd4 : 4'($urandom_range(0, 15));
            s      = 1'($urandom_range(0, 1));
            alu_now = 4'($urandom_range(0, 15));
            set_alu(alu_now);
            #1;

            f = (m_valid && m_es) ? alu_now : m_status;
            pass = model_pass(cond, f);
            chk("rnd.cond_fail", 4'(cond_fail), 4'(!pass));

            model_decode(mode, opcode, s, lg, cmd, es, wb, mr, mw, br);
            upd = m_valid && m_es && (!freeze || flush);
            n_status = upd ? alu_now : m_status;
            {n_cmd, n_valid, n_es, n_wb, n_mr, n_mw, n_br} =
                {m_cmd, m_valid, m_es, m_wb, m_mr, m_mw, m_br};
            if (flush || !freeze) begin
                if (id_valid && lg && pass && !flush)
                    {n_cmd, n_valid, n_es, n_wb, n_mr, n_mw, n_br} = {cmd, 1'b1, es, wb, mr, mw, br};
                else
                    {n_cmd, n_valid, n_es, n_wb, n_mr, n_mw, n_br} = '0;
            end
            if (rst) begin
                n_status = 0;
                {n_cmd, n_valid, n_es, n_wb, n_mr, n_mw, n_br} = '0;
            end

            tick();
            {m_cmd, m_valid, m_es, m_wb, m_mr, m_mw, m_br} =
                {n_cmd, n_valid, n_es, n_wb, n_mr, n_mw, n_br};
            m_status = n_status;
            check_exe("rnd", m_cmd, m_valid, m_es, m_wb, m_mr, m_mw, m_br);
            check_status("rnd", m_status);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
